version_store: RTL

VERSION_STORE -- requirements
Module: version_store

---
 rtl/version_store_pkg.sv | 12 +
 rtl/version_store_slot.sv | 41 ++++
 rtl/version_store.sv | 113 +++++++++++
 3 files changed

// File: rtl/version_store_pkg.sv
// rtl/version_store_pkg.sv - shared defaults and index-width helper for the version store
package version_store_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_VERSION_WIDTH = 4;
  localparam int DEF_VERSION_NUM   = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/version_store_slot.sv
// rtl/version_store_slot.sv - one tagged data slot with write-enable, clear and reset
module versionSlot #(
  parameter int DATA_WIDTH    = 32,
  parameter int VERSION_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic                     i_clear,
  input  logic [VERSION_WIDTH-1:0] i_version,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic [VERSION_WIDTH-1:0] o_version,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_valid
);

  logic [VERSION_WIDTH-1:0] r_version;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_valid;

  // Write wins over clear so a full-store write+free landing on the same slot stays live.
  // Clearing only drops valid; tag and data are kept for inspection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_version <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else if (i_wr_en) begin
      r_version <= i_version;
      r_data    <= i_data;
      r_valid   <= 1'b1;
    end else if (i_clear) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_version = r_version;
  assign o_data    = r_data;
  assign o_valid   = r_valid;

endmodule

// File: rtl/version_store.sv
// rtl/version_store.sv - circular buffer of version-tagged slots with write, free and flush
module version_store
  import version_store_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int VERSION_WIDTH = DEF_VERSION_WIDTH,
  parameter int VERSION_NUM   = DEF_VERSION_NUM
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wrValid,
  input  logic [DATA_WIDTH-1:0]                wrData,
  output logic                                 wrReady,
  input  logic                                 freeValid,
  input  logic                                 flush,
  output logic [VERSION_WIDTH*VERSION_NUM-1:0] versions,
  output logic [DATA_WIDTH*VERSION_NUM-1:0]    dataInputs,
  output logic [VERSION_NUM-1:0]               validMask,
  output logic [VERSION_WIDTH-1:0]             nextVersion,
  output logic [$clog2(VERSION_NUM+1)-1:0]     count,
  output logic                                 full,
  output logic                                 empty
);

  localparam int IW = idx_width(VERSION_NUM);
  localparam int CW = $clog2(VERSION_NUM + 1);

  logic [IW-1:0]            r_head;
  logic [IW-1:0]            r_tail;
  logic [CW-1:0]            r_count;
  logic [VERSION_WIDTH-1:0] r_next_ver;
  logic                     r_full;
  logic                     r_empty;

  logic          w_do_wr;
  logic          w_do_free;
  logic [IW-1:0] w_head_nxt;
  logic [IW-1:0] w_tail_nxt;
  logic [CW-1:0] w_count_nxt;

  // A free in the same cycle makes room, so a full store still accepts the write.
  assign wrReady   = !flush && (!r_full || freeValid);
  assign w_do_wr   = wrValid && wrReady;
  assign w_do_free = freeValid && !r_empty && !flush;

  assign w_head_nxt = (r_head == IW'(VERSION_NUM - 1)) ? '0 : r_head + 1'b1;
  assign w_tail_nxt = (r_tail == IW'(VERSION_NUM - 1)) ? '0 : r_tail + 1'b1;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_wr, w_do_free})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_next_ver <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_do_wr) begin
        r_tail     <= w_tail_nxt;
        r_next_ver <= r_next_ver + 1'b1;
      end
      if (w_do_free) begin
        r_head <= w_head_nxt;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(VERSION_NUM));
      r_empty <= (w_count_nxt == '0);
    end
  end

  for (genvar k = 0; k < VERSION_NUM; k++) begin : g_slot
    logic w_wr_en;
    logic w_clear;
    assign w_wr_en = w_do_wr && (r_tail == IW'(k));
    assign w_clear = flush || (w_do_free && (r_head == IW'(k)));

    versionSlot #(
      .DATA_WIDTH    (DATA_WIDTH),
      .VERSION_WIDTH (VERSION_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr_en),
      .i_clear   (w_clear),
      .i_version (r_next_ver),
      .i_data    (wrData),
      .o_version (versions[k*VERSION_WIDTH +: VERSION_WIDTH]),
      .o_data    (dataInputs[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_valid   (validMask[k])
    );
  end

  assign nextVersion = r_next_ver;
  assign count       = r_count;
  assign full        = r_full;
  assign empty       = r_empty;

endmodule
